fitness_report_tx: RTL and testbench
====================================

Name: fitness_report_tx

Overview:
Serial transmitter that ships one snapshot of the fitness tracker's results off-chip as a framed UART byte stream (8N1, LSB first). It sits downstream of the tracker outputs (activity seconds, calories, speed, THR). On an accepted request it latches all inputs and serialises a fixed 16-byte frame with header and checksum. It is the outbound end of the tracker's report link.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
FRAME_HEADER, 8'hA5, first byte of every frame.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-low reset; 0 = reset.
req_valid  input  1  request to send one report frame.
req_ready  output  1  high when a request can be accepted.
seconds_Run, seconds_Walk, seconds_Cycle  input  8 each  activity times.
calories_Run, calories_Walk, calories_Cycle  input  24 each  calories per activity.
speed  input  8  current speed.
THR  input  8  target heart rate.
tx_serial  output  1  UART line; idle high.
busy  output  1  high while a frame is in flight.
frame_done  output  1  one-cycle pulse at the end of the final stop bit.

Behaviour:
- Reset (rst=0 at an edge): tx_serial=1, busy=0, req_ready=1, frame_done=0. FSM goes to IDLE; bit timer, bit index, byte index and checksum clear to 0.
- Accept: a request is accepted on an edge where req_valid && req_ready. All data inputs are snapshotted at that edge, and later input changes are ignored.
  - req_ready=0 and busy=1 from the next cycle.
  - req_valid while busy is ignored and not queued.
- Frame byte order (index 0..15):
  - 0: FRAME_HEADER
  - 1-3: seconds_Run, seconds_Walk, seconds_Cycle
  - 4-6: calories_Run [23:16], [15:8], [7:0]
  - 7-9: calories_Walk, MSB first
  - 10-12: calories_Cycle, MSB first
  - 13: speed
  - 14: THR
  - 15: checksum = XOR of bytes 1..14 (header excluded)
- FSM states:
  - IDLE -> START on accept.
  - START: tx=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: bits 0..7, LSB first, each CLKS_PER_BIT cycles, then -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index < 15: increment it and go to START, with no inter-byte gap. Otherwise go to IDLE.
- tx_serial is registered. The start bit begins the cycle after accept.
- Frame length is exactly 160*CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle inclusive.
- Frame end: on the last stop-bit cycle, frame_done=1 and req_ready=1 in that same cycle; busy drops the following cycle. A request accepted in that cycle produces a start bit on the very next cycle, giving back-to-back frames with zero idle.
- Reset mid-frame: the frame is abandoned. tx_serial=1 after the reset edge, with no frame_done pulse.
- Widths:
  - Bit timer is clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1, then wraps.
  - Bit index is 3 bits; byte index is 4 bits.
  - Checksum is 8-bit XOR, accumulated at byte load time.

Decomposition:
- Package fitness_pkg holds:
  - FRAME_HEADER default
  - FRAME_BYTES=16 and CHK_IDX=15
  - the tx state enum (IDLE, START, DATA, STOP)
- Sub-module uart_byte_tx: single-byte 8N1 serialiser with start/byte_in/done.
  - Must accept a new byte in its done cycle.
- Parent fitness_report_tx holds:
  - the snapshot registers
  - the byte-index sequencer
  - the checksum
  - the request handshake

Test Plan:
- Reset: CLKS_PER_BIT=4, hold rst=0 for 3 cycles with req_valid=1 -> tx_serial=1, busy=0, req_ready=1, no frame_done.
- Single frame: CLKS_PER_BIT=4.
  - Stimulus: seconds_Run=12, calories_Run=24'h0020D0, speed=3, THR=8'h6B, all others 0; pulse req_valid.
  - Required bytes: A5 0C 00 00 00 20 D0 00 00 00 00 00 00 03 6B 94.
  - frame_done exactly 640 cycles after the first start-bit cycle begins, i.e. on cycle 640 of the frame.
- Snapshot: change every data input at byte 5 of the frame -> the transmitted bytes equal the values held at accept.
- Back-to-back: hold req_valid=1 continuously -> second start bit on the cycle after the first frame_done. Two frame_done pulses 640 cycles apart; tx never idles between frames.
- Reset mid-frame: assert rst=0 for one cycle during byte 5 -> tx_serial=1 next cycle, req_ready=1, busy=0, no frame_done. A subsequent request sends a complete, correct frame.
- All-ones: all inputs 0xFF / 24'hFFFFFF -> payload bytes all FF, checksum 00; each bit held exactly CLKS_PER_BIT cycles, checked with CLKS_PER_BIT=2.

Source files
------------

// File: rtl/fitness_pkg.sv
// Shared types and constants for the fitness tracker report link.
// Holds the frame layout, the serialiser state enum and the snapshot record.
package fitness_pkg;

  localparam logic [7:0] FRAME_HEADER_DEF = 8'hA5;
  localparam int FRAME_BYTES = 16;
  localparam int CHK_IDX = 15;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  typedef struct packed {
    logic [7:0]  sec_run;
    logic [7:0]  sec_walk;
    logic [7:0]  sec_cycle;
    logic [23:0] cal_run;
    logic [23:0] cal_walk;
    logic [23:0] cal_cycle;
    logic [7:0]  speed;
    logic [7:0]  thr;
  } snap_t;

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serialiser, LSB first, registered line output.
// A new byte may be started in the done cycle for gapless streaming.
module uart_byte_tx
  import fitness_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx_serial,
  output logic       done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_e       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shr_q, shr_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign bit_end   = (timer_q == T_LAST);
  assign done      = (state_q == STOP) && bit_end;
  assign tx_serial = tx_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shr_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shr_q   <= shr_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shr_d   = shr_q;
    if (state_q != IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TW'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          shr_d   = byte_in;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shr_d = shr_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (start) begin
            state_d = START;
            shr_d   = byte_in;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the upcoming state so tx stays registered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shr_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/fitness_report_tx.sv
// Report frame transmitter: snapshots tracker results on request and
// streams a 16-byte headed, XOR-checksummed frame over a UART line.
module fitness_report_tx
  import fitness_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  FRAME_HEADER = FRAME_HEADER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  seconds_Run,
  input  logic [7:0]  seconds_Walk,
  input  logic [7:0]  seconds_Cycle,
  input  logic [23:0] calories_Run,
  input  logic [23:0] calories_Walk,
  input  logic [23:0] calories_Cycle,
  input  logic [7:0]  speed,
  input  logic [7:0]  THR,
  output logic        tx_serial,
  output logic        busy,
  output logic        frame_done
);

  snap_t      snap_q, snap_d;
  logic [3:0] idx_q, idx_d, idx_nx;
  logic [7:0] chk_q, chk_d;
  logic       busy_q, busy_d;
  logic       u_start, u_done;
  logic [7:0] u_byte;
  logic       last_byte, accept;
  logic [7:0] fb [FRAME_BYTES];

  assign idx_nx     = idx_q + 4'd1;
  assign last_byte  = (idx_q == 4'(CHK_IDX));
  assign frame_done = busy_q && u_done && last_byte;
  assign req_ready  = !busy_q || frame_done;
  assign accept     = req_valid && req_ready;
  assign busy       = busy_q;
  assign u_byte     = accept ? FRAME_HEADER : fb[idx_nx];

  always_comb begin
    fb[0]  = FRAME_HEADER;
    fb[1]  = snap_q.sec_run;
    fb[2]  = snap_q.sec_walk;
    fb[3]  = snap_q.sec_cycle;
    fb[4]  = snap_q.cal_run[23:16];
    fb[5]  = snap_q.cal_run[15:8];
    fb[6]  = snap_q.cal_run[7:0];
    fb[7]  = snap_q.cal_walk[23:16];
    fb[8]  = snap_q.cal_walk[15:8];
    fb[9]  = snap_q.cal_walk[7:0];
    fb[10] = snap_q.cal_cycle[23:16];
    fb[11] = snap_q.cal_cycle[15:8];
    fb[12] = snap_q.cal_cycle[7:0];
    fb[13] = snap_q.speed;
    fb[14] = snap_q.thr;
    fb[15] = chk_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_q <= '0;
      idx_q  <= '0;
      chk_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      snap_q <= snap_d;
      idx_q  <= idx_d;
      chk_q  <= chk_d;
      busy_q <= busy_d;
    end
  end

  // Checksum folds in each payload byte as it is handed to the serialiser.
  always_comb begin
    snap_d  = snap_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    busy_d  = busy_q;
    u_start = 1'b0;
    if (accept) begin
      snap_d  = '{seconds_Run, seconds_Walk, seconds_Cycle,
                  calories_Run, calories_Walk, calories_Cycle,
                  speed, THR};
      idx_d   = '0;
      chk_d   = '0;
      busy_d  = 1'b1;
      u_start = 1'b1;
    end else if (busy_q && u_done) begin
      if (last_byte) begin
        busy_d = 1'b0;
      end else begin
        idx_d   = idx_nx;
        u_start = 1'b1;
        if (idx_nx != 4'(CHK_IDX)) chk_d = chk_q ^ fb[idx_nx];
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (u_start),
    .byte_in  (u_byte),
    .tx_serial(tx_serial),
    .done     (u_done)
  );

endmodule

// File: tb/tb_fitness_report_tx.sv
// Bench for fitness_report_tx: decodes the UART line cycle by cycle
// and checks frame bytes, bit widths, handshake and reset behaviour.
module tb_fitness_report_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req4, req2;
  logic [7:0]  sr, sw, sc, spd, thr;
  logic [23:0] cr, cw, cc;
  logic        rdy4, tx4, busy4, fd4;
  logic        rdy2, tx2, busy2, fd2;
  logic        sel;
  logic        tx_m, fd_m;
  int          n_chk = 0;
  int          n_fail = 0;

  assign tx_m = sel ? tx2 : tx4;
  assign fd_m = sel ? fd2 : fd4;

  fitness_report_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req4), .req_ready(rdy4),
    .seconds_Run(sr), .seconds_Walk(sw), .seconds_Cycle(sc),
    .calories_Run(cr), .calories_Walk(cw), .calories_Cycle(cc),
    .speed(spd), .THR(thr),
    .tx_serial(tx4), .busy(busy4), .frame_done(fd4)
  );

  fitness_report_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req2), .req_ready(rdy2),
    .seconds_Run(sr), .seconds_Walk(sw), .seconds_Cycle(sc),
    .calories_Run(cr), .calories_Walk(cw), .calories_Cycle(cc),
    .speed(spd), .THR(thr),
    .tx_serial(tx2), .busy(busy2), .frame_done(fd2)
  );

  typedef struct {
    bit           slow2;
    logic [7:0]   sr, sw, sc;
    logic [23:0]  cr, cw, cc;
    logic [7:0]   spd, thr;
    logic [127:0] exp;
  } vec_t;

  vec_t vt[3];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    sr = v.sr; sw = v.sw; sc = v.sc;
    cr = v.cr; cw = v.cw; cc = v.cc;
    spd = v.spd; thr = v.thr;
  endtask

  task automatic send();
    @(negedge clk);
    chk("ready_before_req", sel ? rdy2 : rdy4, 1);
    if (sel) req2 = 1'b1;
    else req4 = 1'b1;
    @(posedge clk);
    #1;
    req2 = 1'b0;
    req4 = 1'b0;
  endtask

  // Returns at the negedge of the last stop-bit cycle.
  task automatic rx_frame(output logic [127:0] got, output int wt,
                          output int done_at, output int bad);
    int   cpb, total, slot, by, bs;
    logic cur;
    cpb = sel ? 2 : 4;
    total = 160 * cpb;
    got = '0; wt = 0; done_at = 0; bad = 0; cur = 1'b1;
    do begin
      @(negedge clk);
      wt++;
    end while (tx_m !== 1'b0 && wt < 100);
    if (tx_m !== 1'b0) begin
      bad = 1;
    end else begin
      for (int k = 0; k < total; k++) begin
        if (k > 0) @(negedge clk);
        slot = k / cpb;
        by = slot / 10;
        bs = slot % 10;
        if (k % cpb == 0) begin
          cur = tx_m;
          if (bs == 0 && cur !== 1'b0) bad++;
          if (bs == 9 && cur !== 1'b1) bad++;
          if (bs >= 1 && bs <= 8) got[120 - by * 8 + bs - 1] = cur;
        end else if (tx_m !== cur) begin
          bad++;
        end
        if (fd_m === 1'b1) begin
          if (k == total - 1) done_at = k + 1;
          else bad++;
        end
      end
    end
  endtask

  task automatic check_frame(input string nm, input logic [127:0] exp);
    logic [127:0] got;
    int wt, done_at, bad, cpb;
    cpb = sel ? 2 : 4;
    rx_frame(got, wt, done_at, bad);
    chk({nm, "_bytes"}, got, exp);
    chk({nm, "_start_latency"}, wt, 1);
    chk({nm, "_done_cycle"}, done_at, 160 * cpb);
    chk({nm, "_framing_errs"}, bad, 0);
  endtask

  initial begin
    int fd_cnt, low_cnt;

    vt[0] = '{1'b0, 8'd12, 8'd0, 8'd0, 24'h0020D0, 24'h0, 24'h0,
              8'd3, 8'h6B, 128'hA50C_0000_0020_D000_0000_0000_0003_6B94};
    vt[1] = '{1'b0, 8'h01, 8'h02, 8'h04, 24'h123456, 24'hABCDEF,
              24'h000080, 8'h55, 8'hAA,
              128'hA501_0204_1234_56AB_CDEF_0000_8055_AA81};
    vt[2] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF, 24'hFFFFFF,
              24'hFFFFFF, 8'hFF, 8'hFF,
              128'hA5FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00};

    sel = 1'b0;
    rst = 1'b0;
    req4 = 1'b1;
    req2 = 1'b1;
    apply(vt[1]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_tx", tx4, 1);
      chk("rst_busy", busy4, 0);
      chk("rst_ready", rdy4, 1);
      chk("rst_done", {fd4, fd2}, 0);
      chk("rst_tx2_busy2", {tx2, busy2, rdy2}, 3'b101);
    end
    @(negedge clk);
    rst = 1'b1;
    req4 = 1'b0;
    req2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", {tx4, busy4, rdy4}, 3'b101);

    for (int i = 0; i < 3; i++) begin
      sel = vt[i].slow2;
      apply(vt[i]);
      send();
      check_frame($sformatf("vec%0d", i), vt[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d_idle", i),
          sel ? {busy2, rdy2, tx2} : {busy4, rdy4, tx4}, 3'b011);
    end

    // Inputs change while byte 5 is on the line.
    sel = 1'b0;
    apply(vt[0]);
    send();
    fork
      check_frame("snapshot", vt[0].exp);
      begin
        repeat (5 * 40 + 2) @(posedge clk);
        #1;
        apply(vt[1]);
      end
    join

    sel = 1'b0;
    apply(vt[1]);
    @(negedge clk);
    req4 = 1'b1;
    check_frame("b2b_first", vt[1].exp);
    check_frame("b2b_second", vt[1].exp);
    req4 = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {busy4, tx4}, 2'b01);

    sel = 1'b0;
    apply(vt[1]);
    send();
    repeat (5 * 40 + 3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_tx", tx4, 1);
    chk("midrst_busy", busy4, 0);
    chk("midrst_ready", rdy4, 1);
    chk("midrst_done", fd4, 0);
    @(negedge clk);
    rst = 1'b1;
    fd_cnt = 0;
    low_cnt = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (fd4 === 1'b1) fd_cnt++;
      if (tx4 !== 1'b1) low_cnt++;
    end
    chk("midrst_no_done", fd_cnt, 0);
    chk("midrst_line_idle", low_cnt, 0);
    apply(vt[0]);
    send();
    check_frame("after_midrst", vt[0].exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
